// File: rtl/dualport_sram_ctrl.sv
// Dual-port (one write, one read) SRAM controller with byte-lane writes,
// write-first read bypass and a hardware clear pass after reset.
//
// State table:
//   CLEAR | zeroing the array one word per cycle, requests ignored, o_busy=1
//   READY | normal operation, writes and reads accepted
//
// Build option: define SRAM_OUT_REG_EN to add an output register after the
// array read (read latency 2 instead of 1).
module dualport_sram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [BE_WIDTH-1:0]   i_wr_be,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_busy
);

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  logic                  state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  ready;
  logic                  rd_fire;

  assign ready   = (state == ST_READY);
  assign o_busy  = ~ready;
  assign rd_fire = ready & i_rd_en;

  // Sequencer: walk clr_cnt across the array once, then enter READY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == LAST_ADDR) begin
        state <= ST_READY;
      end
    end
  end

  // Array write port: clear pass while busy, byte-lane writes once ready
  always_ff @(posedge clk) begin
    if (!ready) begin
      if (!rst) begin
        mem[clr_cnt] <= '0;
      end
    end else if (i_wr_en) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (i_wr_be[b]) begin
          mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read word with write-first bypass of the lanes being written this cycle
  always_comb begin
    rd_word = mem[i_rd_addr];
    if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (i_wr_be[b]) begin
          rd_word[8*b +: 8] = i_wr_data[8*b +: 8];
        end
      end
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  // First read stage: capture the array word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_data <= rd_word;
      end
    end
  end

  // Output stage: data and valid move together, data holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= s1_valid;
      if (s1_valid) begin
        o_rd_data <= s1_data;
      end
    end
  end
`else
  // Single read stage: register the array word straight to the output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= rd_fire;
      if (rd_fire) begin
        o_rd_data <= rd_word;
      end
    end
  end
`endif

endmodule

// File: doc/dualport_sram_ctrl.md
DUALPORT_SRAM_CTRL -- requirements
Module: dualport_sram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, address bits per port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, word width; it SHALL be a multiple of 8.
REQ-003 The block SHALL have derived parameter RAM_DEPTH, default 1<<ADDR_WIDTH, number of words.
REQ-004 The block SHALL have derived parameter BE_WIDTH, default DATA_WIDTH/8, number of byte lanes.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic SHALL act on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 The block SHALL have port i_wr_en, input, 1, write request.
REQ-008 The block SHALL have port i_wr_addr, input, ADDR_WIDTH, write address.
REQ-009 The block SHALL have port i_wr_data, input, DATA_WIDTH, write data.
REQ-010 The block SHALL have port i_wr_be, input, BE_WIDTH, byte enables, where bit k covers data bits [8k+7:8k].
REQ-011 The block SHALL have port i_rd_en, input, 1, read request.
REQ-012 The block SHALL have port i_rd_addr, input, ADDR_WIDTH, read address.
REQ-013 The block SHALL have port o_rd_data, output, DATA_WIDTH, read data.
REQ-014 The block SHALL have port o_rd_valid, output, 1, one-cycle strobe that qualifies o_rd_data.
REQ-015 The block SHALL have port o_busy, output, 1, high while the initialisation clear runs; requests are ignored while it is high.

Function
REQ-016 The block SHALL implement a two-state FSM, CLEAR and READY; reset SHALL force CLEAR.
REQ-017 In CLEAR, the block SHALL write all-zero to address clr_cnt each cycle and increment clr_cnt, which starts at 0.
REQ-018 After writing address RAM_DEPTH-1, the FSM SHALL go to READY on the next edge; o_busy SHALL be high for exactly RAM_DEPTH cycles after rst falls.
REQ-019 In CLEAR, i_wr_en and i_rd_en SHALL be ignored: no memory update, and o_rd_valid SHALL stay 0.
REQ-020 In READY, i_wr_en=1 SHALL update, at the edge, only the byte lanes whose i_wr_be bit is 1; other lanes SHALL keep their old value.
REQ-021 If i_wr_be is all zero with i_wr_en=1, the write SHALL have no effect.
REQ-022 In READY, i_rd_en=1 sampled at edge N SHALL present data on o_rd_data with o_rd_valid=1 after edge N+L-1, where L is the read latency defined under Configuration.
REQ-023 o_rd_valid SHALL be high for exactly one cycle per accepted read; back-to-back reads SHALL give one result per cycle.
REQ-024 o_rd_data SHALL hold its last value when no read completes.
REQ-025 On a same-cycle read and write to the same address, the read SHALL be write-first: enabled lanes SHALL return new data and disabled lanes the stored data.
REQ-026 Reads and writes to different addresses in the same cycle SHALL be independent.

Reset
REQ-027 While rst=1, outputs SHALL be o_rd_data=0, o_rd_valid=0, o_busy=1, with FSM=CLEAR, clr_cnt=0, and the read pipeline flushed.
REQ-028 Memory contents SHALL NOT be reset directly; they SHALL be defined only by the CLEAR pass.
REQ-029 rst asserted during CLEAR or READY SHALL abort the current activity, and release SHALL restart the full clear from address 0.
REQ-030 Any read in flight at reset SHALL be discarded, with no valid strobe.

Configuration
REQ-031 Macro SRAM_OUT_REG_EN, when defined, SHALL add an output register stage after the array read, giving L=2; data and valid SHALL be delayed together.
REQ-032 Without SRAM_OUT_REG_EN, the read SHALL be L=1, with o_rd_data registered directly from the array.
REQ-033 Write-first bypass, byte enables and clear behaviour SHALL be identical in both builds.

Verification
REQ-034 With ADDR_WIDTH=4, pulse rst then release: o_busy SHALL be 1 for 16 cycles then 0, and a read of every address SHALL return 0x00000000.
REQ-035 With ADDR_WIDTH=4, write 0xAABBCCDD to addr 3 with be=4'b0101, then read addr 3: result SHALL be 0x00BB00DD after L cycles with o_rd_valid=1 for one cycle.
REQ-036 With ADDR_WIDTH=4, addr 5 holds 0x11111111; same cycle, write 0x22222222 with be=4'b0011 and read addr 5: result SHALL be 0x11112222.
REQ-037 With ADDR_WIDTH=4, read addrs 0,1,2 on consecutive cycles after writing 1,2,3 to them: o_rd_valid SHALL be high 3 cycles with data 1,2,3 in order.
REQ-038 With ADDR_WIDTH=4, assert rst at clear cycle 7 and release: o_busy SHALL be 1 for a further 16 cycles, and a write issued during busy SHALL leave its address 0.
REQ-039 With ADDR_WIDTH=4, repeat REQ-035 and REQ-036 with SRAM_OUT_REG_EN defined: same data SHALL appear one cycle later.
